series_seq_ctrl: RTL and testbench
==================================

SERIES_SEQ_CTRL -- requirements
Module: series_seq_ctrl

Interface
REQ-001 Parameter CNTR_DEPTH, default 4, width of term counter index and term-count request.
REQ-002 Parameter DATA_W, default 16, signed fixed-point data width for x, coefficients and result.
REQ-003 Parameter FRAC_W, default 8, fractional bits; 1.0 = 1<<FRAC_W.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  1  operation request valid.
REQ-007 req_ready  out  1  block can accept a request; high only in IDLE.
REQ-008 req_x  in  DATA_W  series argument x, signed Q(DATA_W-FRAC_W).FRAC_W.
REQ-009 req_terms  in  CNTR_DEPTH  number of terms N; 0 treated as 1.
REQ-010 start_cntr  out  1  one-cycle pulse that starts the term counter.
REQ-011 done  out  1  stop the term counter; high during the final-term cycle.
REQ-012 coeff_rd_en  in  1  term counter enable / coefficient ROM read strobe.
REQ-013 term_cnt  in  CNTR_DEPTH  current term index k from the term counter.
REQ-014 coeff_data  in  DATA_W  ROM coefficient c[k], valid the cycle after coeff_rd_en with term_cnt=k (1-cycle ROM latency).
REQ-015 res_valid  out  1  result valid; held until res_ready.
REQ-016 res_ready  in  1  result consumer ready.
REQ-017 res_data  out  DATA_W  result sum(c[k]*x^k, k=0..N-1), same Q format.
REQ-018 res_ovf  out  1  at least one saturation occurred during this operation.

Function
REQ-019 FSM states IDLE, START, RUN, DRAIN, RESULT; the block SHALL use exactly this sequence and no others.
REQ-020 IDLE: req_ready=1; on req_valid&req_ready capture x, N (0->1), set pow=1.0, acc=0, ovf=0, go START.
REQ-021 START (1 cycle): start_cntr=1; go RUN.
REQ-022 RUN: done = (term_cnt == N-1) combinationally; when done=1 go DRAIN next cycle; start_cntr=0.
REQ-023 Counter contract: term_cnt = k in the k-th RUN cycle (k=0..N-1); the block SHALL not depend on coeff_rd_en beyond REQ-024.
REQ-024 Coefficient capture: the block SHALL register coeff_rd_en (rd_d1); each cycle rd_d1=1 in RUN or DRAIN, accumulate one term.
REQ-025 Term update: prod = (coeff_data * pow) >>> FRAC_W (arithmetic, full 2*DATA_W product); acc <= sat(acc + prod); pow <= sat((pow * x) >>> FRAC_W).
REQ-026 Saturation: any result outside signed DATA_W range clamps to 0x7FFF/0x8000 (DATA_W=16) and sets ovf sticky.
REQ-027 Terms accumulated SHALL equal N exactly; rd_d1 pulses outside RUN/DRAIN SHALL be ignored.
REQ-028 DRAIN (1 cycle): capture final coefficient c[N-1]; go RESULT.
REQ-029 RESULT: res_valid=1, res_data=acc, res_ovf=ovf, all stable; on res_ready go IDLE; req_ready=0 until IDLE.
REQ-030 Latency: request accepted cycle 0 -> start_cntr cycle 1 -> done cycle N+1 -> res_valid first asserted cycle N+3.
REQ-031 req_valid while not IDLE SHALL be ignored (no capture, no state change).
REQ-032 done SHALL be 0 outside RUN; start_cntr SHALL be 0 outside START.

Reset
REQ-033 rst_n=0 at any clock edge, including mid-RUN: state=IDLE, start_cntr=0, done=0, res_valid=0, res_data=0, res_ovf=0, acc=0, pow=1.0, rd_d1=0.
REQ-034 First request after reset release SHALL behave as from power-up; partial results SHALL be discarded.

Verification
REQ-035 x=0x0100, all c=0x0100, N=4, res_ready=1 -> done cycle 5 only, res_data=0x0400, res_ovf=0, res_valid cycle 7.
REQ-036 x=0x0080, all c=0x0100, N=3 -> res_data=0x01C0 (1.75), res_ovf=0.
REQ-037 req_terms=0, c[0]=0x0123 -> treated as N=1: done in first RUN cycle, res_data=0x0123.
REQ-038 x=0x0100, all c=0x7000, N=4 -> res_data=0x7FFF, res_ovf=1.
REQ-039 res_ready low 5 cycles in RESULT, req_valid high -> res_valid/res_data stable, req_ready=0, no capture; then handshake -> IDLE.
REQ-040 rst_n low 1 cycle during RUN term 2 -> outputs at reset values next cycle; new request x=0x0100, c=0x0100, N=2 -> res_data=0x0200.

Source files
------------

// File: rtl/series_seq_ctrl_if.sv
// Handshake and term-counter bus for series_seq_ctrl.
//   req_*      : operation request (x, term count N) with valid/ready
//   start_cntr : one-cycle pulse that starts the external term counter
//   done       : stops the term counter during the final-term cycle
//   coeff_rd_en, term_cnt, coeff_data : term counter / coefficient ROM
//   res_*      : result with valid/ready, saturation flag
// slave  = the controller side, master = the requester/counter side.
interface series_seq_ctrl_if #(
    parameter int CNTR_DEPTH = 4,
    parameter int DATA_W     = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_W-1:0]     req_x;
    logic [CNTR_DEPTH-1:0] req_terms;
    logic                  start_cntr;
    logic                  done;
    logic                  coeff_rd_en;
    logic [CNTR_DEPTH-1:0] term_cnt;
    logic [DATA_W-1:0]     coeff_data;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_W-1:0]     res_data;
    logic                  res_ovf;

    modport slave (
        input  req_valid, req_x, req_terms, coeff_rd_en, term_cnt, coeff_data, res_ready,
        output req_ready, start_cntr, done, res_valid, res_data, res_ovf
    );

    modport master (
        output req_valid, req_x, req_terms, coeff_rd_en, term_cnt, coeff_data, res_ready,
        input  req_ready, start_cntr, done, res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/series_seq_ctrl.sv
// Power-series evaluator: res = sum(c[k] * x^k, k = 0..N-1) in signed
// Q(DATA_W-FRAC_W).FRAC_W with saturation. The term index comes from an
// external counter started by start_cntr and stopped by done; the ROM
// returns c[k] one cycle after coeff_rd_en.
// Ports: clk, rst_n (synchronous, active-low), bus (series_seq_ctrl_if.slave).
//
// state  | meaning
// IDLE   | ready for a request; captures x and N on handshake
// START  | one-cycle start_cntr pulse
// RUN    | counter stepping; done when term_cnt == N-1
// DRAIN  | absorbs the last coefficient (ROM latency)
// RESULT | res_valid held until res_ready
module series_seq_ctrl #(
    parameter int CNTR_DEPTH = 4,
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8
) (
    input logic            clk,
    input logic            rst_n,
    series_seq_ctrl_if.slave bus
);
    localparam int PW = 2 * DATA_W;
    localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(1 << FRAC_W);
    localparam logic signed [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, RESULT} state_t;

    state_t                    state, state_nxt;
    logic [CNTR_DEPTH-1:0]     n_terms, n_done;
    logic signed [DATA_W-1:0]  x_q, pow, acc;
    logic                      ovf, rd_d1;
    logic                      accept, take;

    logic signed [PW-1:0]      c_ext, p_ext, x_ext, prod, px;
    logic signed [PW:0]        acc_sum, pow_sum;
    logic [DATA_W:0]           acc_sat, pow_sat;

    // Returns {overflow, clamped value}. In range iff all bits from the
    // sign bit of the narrow result upward agree.
    function automatic logic [DATA_W:0] sat(input logic signed [PW:0] v);
        if (v[PW:DATA_W-1] == '0 || v[PW:DATA_W-1] == '1)
            return {1'b0, v[DATA_W-1:0]};
        else if (v[PW])
            return {1'b1, MIN_VAL};
        else
            return {1'b1, MAX_VAL};
    endfunction

    always_comb begin
        c_ext   = PW'($signed(bus.coeff_data));
        p_ext   = PW'(pow);
        x_ext   = PW'(x_q);
        prod    = (c_ext * p_ext) >>> FRAC_W;
        px      = (p_ext * x_ext) >>> FRAC_W;
        acc_sum = (PW+1)'(acc) + (PW+1)'(prod);
        pow_sum = (PW+1)'(px);
        acc_sat = sat(acc_sum);
        pow_sat = sat(pow_sum);
    end

    // The term cap guards against a stray strobe adding an (N+1)th term.
    assign take = rd_d1 && (state == RUN || state == DRAIN) && (n_done != n_terms);

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.start_cntr = 1'b0;
        bus.done       = 1'b0;
        bus.res_valid  = 1'b0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                bus.start_cntr = 1'b1;
                state_nxt      = RUN;
            end
            RUN: begin
                bus.done = (bus.term_cnt == n_terms - CNTR_DEPTH'(1));
                if (bus.done) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = RESULT;
            RESULT: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.res_data = acc;
    assign bus.res_ovf  = ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_q     <= '0;
            n_terms <= '0;
            n_done  <= '0;
            pow     <= ONE;
            acc     <= '0;
            ovf     <= 1'b0;
            rd_d1   <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_d1 <= bus.coeff_rd_en;
            if (accept) begin
                x_q     <= bus.req_x;
                n_terms <= (bus.req_terms == '0) ? CNTR_DEPTH'(1) : bus.req_terms;
                n_done  <= '0;
                pow     <= ONE;
                acc     <= '0;
                ovf     <= 1'b0;
            end else if (take) begin
                acc    <= acc_sat[DATA_W-1:0];
                pow    <= pow_sat[DATA_W-1:0];
                ovf    <= ovf | acc_sat[DATA_W] | pow_sat[DATA_W];
                n_done <= n_done + CNTR_DEPTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_series_seq_ctrl.sv
module tb_series_seq_ctrl;
    localparam int CD = 4;
    localparam int DW = 16;
    localparam int FW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    series_seq_ctrl_if #(.CNTR_DEPTH(CD), .DATA_W(DW)) bus();

    series_seq_ctrl #(.CNTR_DEPTH(CD), .DATA_W(DW), .FRAC_W(FW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Term counter and coefficient ROM model: c[0]=c0_m, c[1]=c1_m, else cr_m.
    logic [DW-1:0] c0_m, c1_m, cr_m;
    logic          cnt_on;

    function automatic logic [DW-1:0] coef(input logic [CD-1:0] k);
        if (k == 0) return c0_m;
        else if (k == 1) return c1_m;
        else return cr_m;
    endfunction

    assign bus.coeff_rd_en = cnt_on;

    always @(posedge clk) begin
        if (!rst_n) begin
            cnt_on         <= 1'b0;
            bus.term_cnt   <= '0;
            bus.coeff_data <= '0;
        end else begin
            if (bus.coeff_rd_en) bus.coeff_data <= coef(bus.term_cnt);
            if (bus.start_cntr) begin
                cnt_on       <= 1'b1;
                bus.term_cnt <= '0;
            end else if (cnt_on) begin
                if (bus.done) cnt_on <= 1'b0;
                else bus.term_cnt <= bus.term_cnt + 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full operation. hold>0 keeps res_ready low for hold extra RESULT
    // cycles while a competing request is presented.
    task automatic run_op(input string tag, input logic [DW-1:0] x,
                          input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                          input logic [DW-1:0] cr, input logic [CD-1:0] n,
                          input logic [DW-1:0] exp_data, input logic exp_ovf,
                          input int hold);
        int ne = (n == 0) ? 1 : int'(n);
        int start_cnt = 0, start_at = -1, done_cnt = 0, done_at = -1, rv_at = -1;
        logic [DW-1:0] held;
        @(negedge clk);
        check({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
        c0_m = c0; c1_m = c1; cr_m = cr;
        bus.req_x = x;
        bus.req_terms = n;
        bus.req_valid = 1'b1;
        bus.res_ready = (hold > 0) ? 1'b0 : 1'b1;
        for (int cyc = 1; cyc <= 40 && rv_at < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.req_valid = 1'b0;
            if (bus.start_cntr) begin
                start_cnt++;
                if (start_at < 0) start_at = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (bus.res_valid) rv_at = cyc;
        end
        check({tag, " start count"}, 32'(start_cnt), 32'd1);
        check({tag, " start cycle"}, 32'(start_at), 32'd1);
        check({tag, " done count"}, 32'(done_cnt), 32'd1);
        check({tag, " done cycle"}, 32'(done_at), 32'(ne + 1));
        check({tag, " res_valid cycle"}, 32'(rv_at), 32'(ne + 3));
        check({tag, " res_data"}, 32'(bus.res_data), 32'(exp_data));
        check({tag, " res_ovf"}, 32'(bus.res_ovf), 32'(exp_ovf));
        if (hold > 0) begin
            held = bus.res_data;
            bus.req_x = 16'h7777;
            bus.req_terms = 4'd9;
            bus.req_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({tag, " stall res_valid"}, 32'(bus.res_valid), 32'd1);
                check({tag, " stall res_data"}, 32'(bus.res_data), 32'(held));
                check({tag, " stall req_ready"}, 32'(bus.req_ready), 32'd0);
                check({tag, " stall start_cntr"}, 32'(bus.start_cntr), 32'd0);
            end
            bus.req_valid = 1'b0;
            bus.res_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, " back idle res_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, " back idle req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, " back idle start_cntr"}, 32'(bus.start_cntr), 32'd0);
    endtask

    typedef struct {
        string         name;
        logic [DW-1:0] x;
        logic [DW-1:0] c0;
        logic [DW-1:0] c1;
        logic [DW-1:0] cr;
        logic [CD-1:0] n;
        logic [DW-1:0] exp_data;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"unit_n4",   16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'd4,  16'h0400, 1'b0};
        vecs[1] = '{"half_n3",   16'h0080, 16'h0100, 16'h0100, 16'h0100, 4'd3,  16'h01C0, 1'b0};
        vecs[2] = '{"n_zero",    16'h0200, 16'h0123, 16'h0100, 16'h0100, 4'd0,  16'h0123, 1'b0};
        vecs[3] = '{"sat_pos",   16'h0100, 16'h7000, 16'h7000, 16'h7000, 4'd4,  16'h7FFF, 1'b1};
        vecs[4] = '{"two_n3",    16'h0200, 16'h0100, 16'h0100, 16'h0100, 4'd3,  16'h0700, 1'b0};
        vecs[5] = '{"neg_x",     16'hFF00, 16'h0100, 16'h0100, 16'h0100, 4'd4,  16'h0000, 1'b0};
        vecs[6] = '{"sat_neg",   16'h0100, 16'h9000, 16'h9000, 16'h9000, 4'd2,  16'h8000, 1'b1};
        vecs[7] = '{"sticky",    16'h0100, 16'h7000, 16'h7000, 16'h9000, 4'd3,  16'h0FFF, 1'b1};
        vecs[8] = '{"frac_n5",   16'h0080, 16'h0000, 16'h0040, 16'h0040, 4'd5,  16'h003C, 1'b0};
        vecs[9] = '{"max_n15",   16'h0100, 16'h0010, 16'h0010, 16'h0010, 4'd15, 16'h00F0, 1'b0};

        bus.req_valid = 1'b0;
        bus.req_x     = '0;
        bus.req_terms = '0;
        bus.res_ready = 1'b1;
        c0_m = '0; c1_m = '0; cr_m = '0;

        repeat (3) @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset start_cntr", 32'(bus.start_cntr), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset res_valid", 32'(bus.res_valid), 32'd0);
        check("reset res_data", 32'(bus.res_data), 32'd0);
        check("reset res_ovf", 32'(bus.res_ovf), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].name, vecs[i].x, vecs[i].c0, vecs[i].c1, vecs[i].cr,
                   vecs[i].n, vecs[i].exp_data, vecs[i].exp_ovf, 0);

        // Result stall with a competing request.
        run_op("stall", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'd2, 16'h0200, 1'b0, 5);
        run_op("after_stall", 16'h0080, 16'h0100, 16'h0100, 16'h0100, 4'd3, 16'h01C0, 1'b0, 0);

        // Reset during RUN term 2 discards the partial result.
        begin
            bit seen = 1'b0;
            @(negedge clk);
            c0_m = 16'h7000; c1_m = 16'h7000; cr_m = 16'h7000;
            bus.req_x = 16'h0100;
            bus.req_terms = 4'd4;
            bus.req_valid = 1'b1;
            for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
                @(negedge clk);
                bus.req_valid = 1'b0;
                if (cnt_on && bus.term_cnt == 4'd2) seen = 1'b1;
            end
            check("midrun reached term 2", 32'(seen), 32'd1);
            check("midrun partial acc", 32'(bus.res_data), 32'h7000);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("midrun rst req_ready", 32'(bus.req_ready), 32'd1);
            check("midrun rst start_cntr", 32'(bus.start_cntr), 32'd0);
            check("midrun rst done", 32'(bus.done), 32'd0);
            check("midrun rst res_valid", 32'(bus.res_valid), 32'd0);
            check("midrun rst res_data", 32'(bus.res_data), 32'd0);
            check("midrun rst res_ovf", 32'(bus.res_ovf), 32'd0);
        end
        run_op("post_reset", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'd2, 16'h0200, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
